// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants, FSM states and display record for the seven-segment scanner
package seven_seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DEF_SCAN_DIV = 1000;
  localparam int DEF_BLANK_CYC = 8;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
  } disp_t;
endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if: load/data inputs and decoder/anode outputs of the scanner
interface seven_seg_scan_ctrl_if;
  import seven_seg_pkg::*;
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [3:0]              seg_nib;
  logic                    seg_dp;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    load_ack;
  logic                    frame_start;
  modport master (
    output en, load, data_in, dp_in, blank_in,
    input  seg_nib, seg_dp, an_n, load_ack, frame_start
  );
  modport slave (
    input  en, load, data_in, dp_in, blank_in,
    output seg_nib, seg_dp, an_n, load_ack, frame_start
  );
endinterface

// File: rtl/seven_seg_slot_timer.sv
// seven_seg_slot_timer: per-slot cycle counter flagging the end of the blank phase and of the slot
module seven_seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);
  localparam int W = $clog2(SCAN_DIV);
  localparam logic [W-1:0] BLANK_LAST = W'(BLANK_CYC - 1);
  localparam logic [W-1:0] SLOT_LAST = W'(SCAN_DIV - 1);
  logic [W-1:0] cnt;
  // counter is held at zero whenever the scan is not running
  always_ff @(posedge clk)
    if (!rst_n || !run) cnt <= '0;
    else cnt <= slot_done ? '0 : cnt + W'(1);
  assign blank_done = run && cnt == BLANK_LAST;
  assign slot_done = run && cnt == SLOT_LAST;
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: four-digit multiplexed display scanner; define SEVEN_SEG_LZS_EN for leading-zero suppression
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input logic clk,
  input logic rst_n,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  disp_t disp, disp_nx, pend;
  logic pending, run, slot_start, commit, blank_done, slot_done;
  logic [NUM_DIGITS-1:0] dark;
  logic [3:0] seg_nib;
  logic seg_dp, load_ack, frame_start;

  assign run = bus.en && state != IDLE;

  seven_seg_slot_timer #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .blank_done(blank_done),
    .slot_done(slot_done)
  );

  // state and digit index registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
    end

  // a slot starts on enable or after a drive phase; pending data commits only at a digit-0 slot start
  always_comb begin
    slot_start = bus.en && (state == IDLE || (state == DRIVE && slot_done));
    state_nx = !bus.en ? IDLE : slot_start ? BLANK : (state == BLANK && blank_done) ? DRIVE : state;
    idx_nx = (bus.en && state == DRIVE && slot_done) ? idx + IW'(1) : idx;
    commit = slot_start && idx_nx == '0 && pending;
    disp_nx = commit ? pend : disp;
  end

  // shadow/display registers and slot-latched decoder outputs
  always_ff @(posedge clk)
    if (!rst_n) begin
      disp <= '0;
      pend <= '0;
      pending <= 1'b0;
      seg_nib <= '0;
      seg_dp <= 1'b0;
      load_ack <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      disp <= disp_nx;
      pend <= bus.load ? '{data: bus.data_in, dp: bus.dp_in, blank: bus.blank_in} : pend;
      pending <= bus.load || (pending && !commit);
      load_ack <= commit;
      frame_start <= slot_start && idx_nx == '0;
      if (slot_start) begin
        seg_nib <= disp_nx.data[{idx_nx, 2'b00} +: 4];
        seg_dp <= disp_nx.dp[idx_nx];
      end
    end

`ifdef SEVEN_SEG_LZS_EN
  logic [NUM_DIGITS-1:0] lz;
  logic lead;
  // digits from the top stay suppressed while zero with no dp; digit 0 always shows
  always_comb begin
    lz = '0;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead = lead && disp.data[4*i +: 4] == 4'd0 && !disp.dp[i];
      lz[i] = lead;
    end
  end
  assign dark = disp.blank | lz;
`else
  assign dark = disp.blank;
`endif

  assign bus.an_n = (state == DRIVE && !dark[idx]) ? ~(NUM_DIGITS'(1) << idx) : '1;
  assign bus.seg_nib = seg_nib;
  assign bus.seg_dp = seg_dp;
  assign bus.load_ack = load_ack;
  assign bus.frame_start = frame_start;
endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, 1000, clk cycles per digit slot (blank + drive); legal range 4..65535.
REQ-002 Parameter BLANK_CYC, 8, anti-ghost blank cycles at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  scan enable; low holds the display dark.
REQ-006 load  input  1  single-cycle strobe capturing data_in/dp_in/blank_in.
REQ-007 data_in  input  16  four BCD/hex nibbles; [3:0] is digit 0 (rightmost).
REQ-008 dp_in  input  4  decimal point per digit, active-high.
REQ-009 blank_in  input  4  per-digit blank mask, 1 = dark.
REQ-010 seg_nib  output  4  nibble to the shared segment decoder ({a,b,c,d}, a = MSB).
REQ-011 seg_dp  output  1  decimal point for the current digit.
REQ-012 an_n  output  4  one-hot-low anode enables, bit i = digit i.
REQ-013 load_ack  output  1  one-cycle pulse when captured data becomes displayed.
REQ-014 frame_start  output  1  one-cycle pulse on the first cycle of the digit-0 slot.

Function
REQ-015 FSM states: IDLE, BLANK, DRIVE; IDLE -> BLANK on the first cycle with en=1.
REQ-016 BLANK lasts exactly BLANK_CYC cycles with an_n=4'hF; DRIVE lasts SCAN_DIV-BLANK_CYC cycles with an_n[idx]=0 unless digit idx is blanked.
REQ-017 DRIVE -> BLANK on slot end; digit index idx increments 0->1->2->3->0, with wrap-around.
REQ-018 seg_nib/seg_dp change only on the first BLANK cycle of a slot and stay stable through that slot.
REQ-019 load writes a pending shadow register; a later load before commit overwrites it (latest wins).
REQ-020 Pending data commits to the display register on the first cycle of the digit-0 slot, asserting load_ack that cycle; no tearing within a frame.
REQ-021 load coincident with the commit cycle: the older pending data commits, and the new data stays pending for the next frame.
REQ-022 en deasserted: next cycle an_n=4'hF, FSM -> IDLE, slot counter cleared; idx and registers retained; re-enable resumes with BLANK at the retained idx.
REQ-023 Slot counter width is $clog2(SCAN_DIV); no other arithmetic.

Reset
REQ-024 On rst_n=0 at a clk edge: state=IDLE, idx=0, counter=0, an_n=4'hF, seg_nib=0, seg_dp=0, load_ack=0, frame_start=0.
REQ-025 The display register and the pending register clear to 0 with no pending flag.
REQ-026 Reset mid-slot takes priority over en/load in the same cycle, and the display goes dark on the next cycle.

Configuration
REQ-027 Macro SEVEN_SEG_LZS_EN: when defined, leading-zero suppression is active; from digit 3 downward, digits with nibble 0 and dp 0 are treated as blanked until the first non-zero digit; digit 0 is never suppressed.
REQ-028 Without SEVEN_SEG_LZS_EN, only blank_in controls blanking, and the suppression logic is absent from the netlist.

Structure
REQ-029 Package seven_seg_pkg holds NUM_DIGITS=4, the FSM state typedef, and the default SCAN_DIV/BLANK_CYC constants.
REQ-030 One sub-module, seven_seg_slot_timer, contains the slot counter and emits blank_done/slot_done pulses.
REQ-031 The segment decoder is external; this block drives its inputs only.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-032 Reset release, en=1, load data_in=16'h1234 -> load_ack at first digit-0 slot; an_n sequence E,D,B,7 with 6-cycle lows separated by 2-cycle 4'hF; seg_nib 4,3,2,1.
REQ-033 Two loads 16'hAAAA then 16'h5555 within one frame -> only 16'h5555 is displayed; one load_ack.
REQ-034 blank_in=4'b0100, dp_in=4'b0001 -> an_n[2] never low; seg_dp=1 only in the digit-0 slot.
REQ-035 en dropped mid-DRIVE of digit 2 for 5 cycles -> an_n=4'hF next cycle; on re-enable, 2 BLANK cycles then an_n=4'hB.
REQ-036 Reset asserted mid-frame with load pending -> all outputs at reset values next cycle; the pending data is never acked.
REQ-037 With SEVEN_SEG_LZS_EN defined, data_in=16'h0070 -> digits 3 and 2 dark, digits 1 (7) and 0 (0) lit; data_in=16'h0000 -> only digit 0 lit.
